mc_core_sequencer: RTL and testbench
====================================

Name: mc_core_sequencer

Overview:
Parametrised multicycle control sequencer for the MIPS-subset core. It owns the PC and IR and steps each instruction through the IF/ID/EXE/MEM/WB states, raising datapath strobes as it goes. Unlike the fixed-timing controller, it adds variable-latency ready handshakes on instruction and data memory, a wait-timeout fault state, single-step mode, an external pause, and an instruction-retire counter. It sits between the memories and the register-file/ALU datapath, and its 3-bit state drives the existing state display.

Parameters:
ADDR_W, 32, PC / memory address width (>= 8, multiple of 4 not required; the low 2 bits are always 0).
RESET_PC, 0, PC value loaded on reset.
CNT_W, 32, retire counter width.
MAX_WAIT, 15, maximum consecutive wait cycles on one memory request before FAULT (1..255).

Ports:
clk  in  1  processor clock; all logic is on the rising edge.
reset  in  1  synchronous reset, active-high.
enable  in  1  advance enable; 0 freezes all state.
step_mode  in  1  1 = execute one instruction per step_req.
step_req  in  1  single-cycle pulse that releases one instruction in step mode.
halt_signal  in  1  external pause, honoured at instruction boundary.
imem_req  out  1  instruction fetch request.
imem_addr  out  ADDR_W  fetch address (= pc).
imem_rdata  in  32  fetched instruction.
imem_ready  in  1  fetch complete; sampled only while imem_req=1.
dmem_req  out  1  data access request.
dmem_we  out  1  1 = store.
dmem_ready  in  1  data access complete; sampled only while dmem_req=1.
zero_flag  in  1  ALU zero, valid in EXE.
ir  out  32  instruction register.
pc  out  ADDR_W  program counter.
current_state  out  3  FSM state encoding.
reg_write  out  1  register-file write strobe.
reg_dst  out  1  1 = rd, 0 = rt.
alu_src_b  out  1  1 = extended immediate.
mem_to_reg  out  1  1 = write-back from data memory.
retire_count  out  CNT_W  instructions retired.
fault  out  1  sticky fault flag.

Behaviour:
- Reset values: pc=RESET_PC; ir=0; state=IF; retire_count=0; fault=0; all strobes and requests=0. Reset overrides enable and applies in any state, including mid-request.
- enable=0: no register changes. imem_req and dmem_req hold their value. reg_write is forced to 0.
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101, FAULT=110.
- IF, boundary gate: imem_req stays low while any of the following holds:
  - halt_signal=1;
  - step_mode=1 and no step credit is held.
  - A step_req pulse sets a 1-bit credit. The credit is consumed when the fetch is issued. Extra pulses while the credit is already set are ignored.
- IF, fetch: assert imem_req with imem_addr=pc, both held stable until ready. When imem_ready=1 in a req cycle, latch ir<=imem_rdata and go to ID. Ready in the first req cycle is legal and gives a 1-cycle IF.
- ID:
  - opcode 111111 goes to HALT.
  - j (000010): pc <= {pc_plus4 upper bits, target, 2'b00} truncated to ADDR_W; retire; go to IF.
  - Any other opcode goes to EXE.
- EXE:
  - beq (000100) / bne (000101): taken when zero_flag==1 / ==0. Taken gives pc <= pc+4+(sext(imm)<<2); not taken gives pc <= pc+4. Both retire and go to IF.
  - lw (100011) / sw (101011) go to MEM.
  - R-type (000000), addi (001000), ori (001101) go to WB.
  - Any other opcode goes to FAULT.
- MEM: assert dmem_req, with dmem_we=1 for sw. On dmem_ready: sw gives pc+4, retire, IF; lw goes to WB.
- WB: reg_write=1 for exactly one cycle; pc+4; retire; go to IF.
- Decode outputs (combinational from ir, valid ID..WB):
  - reg_dst=1 for R-type;
  - alu_src_b=1 for addi/ori/lw/sw;
  - mem_to_reg=1 for lw.
- Latency at zero wait: j 2 cycles; beq/bne 3; R/addi/ori/sw 4; lw 5.
- Wait timeout: a counter clears when a request starts and increments on each req cycle with ready=0. When it reaches MAX_WAIT, go to FAULT with the request dropped the next cycle. Ready on the same cycle the count hits MAX_WAIT wins: the transfer completes and there is no fault.
- HALT / FAULT: terminal until reset. All requests and strobes are 0; pc and ir hold. fault=1 in FAULT only.
- Arithmetic: pc arithmetic is modulo 2^ADDR_W. retire_count wraps to 0 after all-ones. Retire means a single-cycle increment at instruction completion.

Test Plan:
- Reset then addi $1,$0,5 (0x20010005) at pc 0, ready immediate → states IF,ID,EXE,WB over 4 cycles; one-cycle reg_write with alu_src_b=1; pc=4; retire_count=1.
- lw with dmem_ready delayed 3 cycles → MEM lasts 4 cycles, dmem_we=0, then WB with mem_to_reg=1; pc+4. Then sw → dmem_we=1, no reg_write.
- beq offset 0x0003 at pc 0x10: zero_flag=1 → pc=0x20; zero_flag=0 → pc=0x14. bne with zero_flag=0 → pc=0x20.
- imem_ready held 0 with MAX_WAIT=15 → FAULT (110) after 15 wait cycles, fault=1, imem_req low. Ready on exactly the 15th cycle → no fault.
- step_mode=1 → no imem_req until step_req; one pulse retires exactly one instruction. halt_signal=1 mid-instruction → the current instruction completes, then IF waits with no request.
- Opcode 0xFC000000 → HALT (101) after ID; retire unchanged. Reset asserted mid-MEM → pc=RESET_PC, state IF, dmem_req=0 the next cycle.

Source files
------------

// File: rtl/mc_core_sequencer_if.sv
// Memory-side handshake bundle for the multicycle sequencer.
// master = sequencer, slave = instruction/data memory side.
interface mc_core_sequencer_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/mc_core_sequencer.sv
// Multicycle control sequencer: owns PC/IR, walks IF/ID/EXE/MEM/WB with
// ready handshakes on both memories, wait timeout, step mode and pause.
module mc_core_sequencer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32,
    parameter int unsigned       MAX_WAIT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       step_mode,
    input  logic                       step_req,
    input  logic                       halt_signal,
    mc_core_sequencer_if.master        mem,
    input  logic                       zero_flag,
    output logic [31:0]                ir,
    output logic [ADDR_W-1:0]          pc,
    output logic [2:0]                 current_state,
    output logic                       reg_write,
    output logic                       reg_dst,
    output logic                       alu_src_b,
    output logic                       mem_to_reg,
    output logic [CNT_W-1:0]           retire_count,
    output logic                       fault
);

    typedef enum logic [2:0] {
        StIf    = 3'b000,
        StId    = 3'b001,
        StExe   = 3'b010,
        StMem   = 3'b011,
        StWb    = 3'b100,
        StHalt  = 3'b101,
        StFault = 3'b110
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpHalt  = 6'b111111;

    // Timeout fires on the MAX_WAIT-th consecutive not-ready request cycle.
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  retire_q;
    logic              retire;
    logic              credit_q, credit_d;
    logic              fetch_q, fetch_d;
    logic [7:0]        wait_q, wait_d;
    logic              ireq_q;

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_mask;
    logic [ADDR_W-1:0] jmp_target;
    logic              gate_open;
    logic              imem_req_c;
    logic              dmem_req_c;
    logic              req_active;
    logic              req_ready;
    logic              timeout;
    logic              in_exec;

    // Shared datapath terms and handshake bookkeeping
    always_comb begin
        opcode     = ir_q[31:26];
        pc_plus4   = pc_q + ADDR_W'(4);
        br_off     = ADDR_W'($signed({{14{ir_q[15]}}, ir_q[15:0], 2'b00}));
        jmp_mask   = ADDR_W'(32'h0FFF_FFFF);
        jmp_target = (pc_plus4 & ~jmp_mask) | (ADDR_W'({ir_q[25:0], 2'b00}) & jmp_mask);
        gate_open  = !halt_signal && (!step_mode || credit_q);
        // Once a fetch is in flight it stays up regardless of the gate.
        imem_req_c = (state_q == StIf) && (fetch_q || gate_open);
        dmem_req_c = (state_q == StMem);
        req_active = imem_req_c || dmem_req_c;
        req_ready  = (imem_req_c && mem.imem_ready) || (dmem_req_c && mem.dmem_ready);
        timeout    = req_active && !req_ready && (wait_q == WaitLast);
        wait_d     = (req_active && !req_ready) ? wait_q + 8'd1 : 8'd0;
        fetch_d    = imem_req_c && !mem.imem_ready && !timeout;
        credit_d   = (imem_req_c && !fetch_q) ? 1'b0 : (credit_q | step_req);
    end

    // State, PC/IR, retire counter and handshake registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIf;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            retire_q <= '0;
            credit_q <= 1'b0;
            fetch_q  <= 1'b0;
            wait_q   <= '0;
            ireq_q   <= 1'b0;
        end else if (enable) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            retire_q <= retire ? retire_q + CNT_W'(1) : retire_q;
            credit_q <= credit_d;
            fetch_q  <= fetch_d;
            wait_q   <= wait_d;
            ireq_q   <= imem_req_c;
        end
    end

    // Next-state and transition actions (PC update, IR latch, retire)
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        retire  = 1'b0;
        unique case (state_q)
            StIf: begin
                if (imem_req_c) begin
                    if (mem.imem_ready) begin
                        ir_d    = mem.imem_rdata;
                        state_d = StId;
                    end else if (timeout) begin
                        state_d = StFault;
                    end
                end
            end
            StId: begin
                if (opcode == OpHalt) begin
                    state_d = StHalt;
                end else if (opcode == OpJ) begin
                    pc_d    = jmp_target;
                    retire  = 1'b1;
                    state_d = StIf;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                if (opcode == OpBeq || opcode == OpBne) begin
                    if ((opcode == OpBeq) == zero_flag) pc_d = pc_plus4 + br_off;
                    else                                 pc_d = pc_plus4;
                    retire  = 1'b1;
                    state_d = StIf;
                end else if (opcode == OpLw || opcode == OpSw) begin
                    state_d = StMem;
                end else if (opcode == OpRtype || opcode == OpAddi || opcode == OpOri) begin
                    state_d = StWb;
                end else begin
                    state_d = StFault;
                end
            end
            StMem: begin
                if (mem.dmem_ready) begin
                    if (opcode == OpSw) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = StIf;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StWb: begin
                pc_d    = pc_plus4;
                retire  = 1'b1;
                state_d = StIf;
            end
            StHalt:  state_d = StHalt;
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase
    end

    // Outputs: requests, strobes and decode lines
    always_comb begin
        in_exec       = (state_q == StId) || (state_q == StExe) ||
                        (state_q == StMem) || (state_q == StWb);
        // While disabled the fetch request repeats its last driven value.
        mem.imem_req  = reset ? 1'b0 : (enable ? imem_req_c : ireq_q);
        mem.imem_addr = pc_q;
        mem.dmem_req  = !reset && dmem_req_c;
        mem.dmem_we   = !reset && dmem_req_c && (opcode == OpSw);
        reg_write     = !reset && enable && (state_q == StWb);
        reg_dst       = in_exec && (opcode == OpRtype);
        alu_src_b     = in_exec && (opcode == OpAddi || opcode == OpOri ||
                                    opcode == OpLw   || opcode == OpSw);
        mem_to_reg    = in_exec && (opcode == OpLw);
        fault         = (state_q == StFault);
        current_state = state_q;
        pc            = pc_q;
        ir            = ir_q;
        retire_count  = retire_q;
    end

endmodule

// File: tb/tb_mc_core_sequencer.sv
// Directed bench for mc_core_sequencer: hand-computed expectations per step.
module tb_mc_core_sequencer;

    localparam logic [31:0] ADDI  = 32'h2001_0005;
    localparam logic [31:0] LW    = 32'h8C22_0000;
    localparam logic [31:0] SW    = 32'hAC22_0004;
    localparam logic [31:0] J10   = 32'h0800_0004;
    localparam logic [31:0] BEQ3  = 32'h1000_0003;
    localparam logic [31:0] BNE3  = 32'h1400_0003;
    localparam logic [31:0] BEQM1 = 32'h1000_FFFF;
    localparam logic [31:0] HALTI = 32'hFC00_0000;
    localparam logic [31:0] BAD   = 32'h0C00_0000;

    logic        clk = 1'b0;
    logic        reset, enable, step_mode, step_req, halt_signal, zero_flag;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [2:0]  current_state;
    logic        reg_write, reg_dst, alu_src_b, mem_to_reg, fault;
    logic [31:0] retire_count;

    int checks   = 0;
    int failures = 0;
    int n, wb;

    mc_core_sequencer_if #(.ADDR_W(32)) bus ();

    mc_core_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .CNT_W    (32),
        .MAX_WAIT (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .step_mode     (step_mode),
        .step_req      (step_req),
        .halt_signal   (halt_signal),
        .mem           (bus),
        .zero_flag     (zero_flag),
        .ir            (ir),
        .pc            (pc),
        .current_state (current_state),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .alu_src_b     (alu_src_b),
        .mem_to_reg    (mem_to_reg),
        .retire_count  (retire_count),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from IF with zero-wait memories; stops on IF/HALT/FAULT.
    task automatic exec(input logic [31:0] instr, input logic zf, output int cycles,
                        output int wbs);
        bus.imem_rdata = instr;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        zero_flag      = zf;
        cycles         = 0;
        wbs            = 0;
        do begin
            cyc();
            cycles++;
            bus.imem_ready = 1'b0;
            if (reg_write) wbs++;
        end while (!(current_state inside {3'b000, 3'b101, 3'b110}) && cycles < 30);
        bus.dmem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; step_mode = 1'b0; step_req = 1'b0;
        halt_signal = 1'b0; zero_flag = 1'b0;
        bus.imem_rdata = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        repeat (2) cyc();

        // Reset state
        chk("rst_state", current_state, 3'b000);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_retire", retire_count, 0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_dmem_req", bus.dmem_req, 1'b0);
        chk("rst_reg_write", reg_write, 1'b0);

        // addi, walked cycle by cycle
        reset = 1'b0; bus.imem_rdata = ADDI; bus.imem_ready = 1'b1; #1;
        chk("addi_if_req", bus.imem_req, 1'b1);
        chk("addi_if_addr", bus.imem_addr, 32'h0);
        cyc(); bus.imem_ready = 1'b0;
        chk("addi_id_state", current_state, 3'b001);
        chk("addi_ir", ir, ADDI);
        chk("addi_id_alusrc", alu_src_b, 1'b1);
        chk("addi_id_regdst", reg_dst, 1'b0);
        cyc();
        chk("addi_exe_state", current_state, 3'b010);
        cyc();
        chk("addi_wb_state", current_state, 3'b100);
        chk("addi_wb_regwrite", reg_write, 1'b1);
        cyc();
        chk("addi_done_state", current_state, 3'b000);
        chk("addi_done_regwrite", reg_write, 1'b0);
        chk("addi_pc", pc, 32'h4);
        chk("addi_retire", retire_count, 1);

        // lw with dmem_ready delayed 3 cycles
        bus.imem_rdata = LW; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
        cyc(); bus.imem_ready = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_state", current_state, 3'b011);
            chk("lw_mem_req", bus.dmem_req, 1'b1);
            chk("lw_mem_we", bus.dmem_we, 1'b0);
            cyc();
        end
        chk("lw_mem4_state", current_state, 3'b011);
        bus.dmem_ready = 1'b1;
        cyc(); bus.dmem_ready = 1'b0;
        chk("lw_wb_state", current_state, 3'b100);
        chk("lw_wb_memtoreg", mem_to_reg, 1'b1);
        chk("lw_wb_regwrite", reg_write, 1'b1);
        cyc();
        chk("lw_pc", pc, 32'h8);
        chk("lw_retire", retire_count, 2);

        // sw with immediate ready
        bus.imem_rdata = SW; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        cyc(); bus.imem_ready = 1'b0;
        cyc(); cyc();
        chk("sw_mem_req", bus.dmem_req, 1'b1);
        chk("sw_mem_we", bus.dmem_we, 1'b1);
        chk("sw_mem_regwrite", reg_write, 1'b0);
        cyc(); bus.dmem_ready = 1'b0;
        chk("sw_done_state", current_state, 3'b000);
        chk("sw_done_dmem_req", bus.dmem_req, 1'b0);
        chk("sw_pc", pc, 32'hC);
        chk("sw_retire", retire_count, 3);

        // Jumps and branches
        exec(J10, 1'b0, n, wb);
        chk("j_cycles", n, 2);
        chk("j_pc", pc, 32'h10);
        chk("j_retire", retire_count, 4);
        exec(BEQ3, 1'b1, n, wb);
        chk("beq_t_cycles", n, 3);
        chk("beq_t_pc", pc, 32'h20);
        exec(J10, 1'b0, n, wb);
        chk("j2_pc", pc, 32'h10);
        exec(BEQ3, 1'b0, n, wb);
        chk("beq_nt_pc", pc, 32'h14);
        exec(J10, 1'b0, n, wb);
        exec(BNE3, 1'b0, n, wb);
        chk("bne_t_cycles", n, 3);
        chk("bne_t_pc", pc, 32'h20);
        exec(BEQM1, 1'b1, n, wb);
        chk("beq_neg_pc", pc, 32'h20);
        chk("branch_retire", retire_count, 10);

        // Zero-wait latencies and write-back pulse counts
        exec(ADDI, 1'b0, n, wb);
        chk("addi_cycles", n, 4);
        chk("addi_wb_pulses", wb, 1);
        exec(LW, 1'b0, n, wb);
        chk("lw_cycles", n, 5);
        chk("lw_wb_pulses", wb, 1);
        exec(SW, 1'b0, n, wb);
        chk("sw_cycles", n, 4);
        chk("sw_wb_pulses", wb, 0);
        chk("seq_pc", pc, 32'h2C);
        chk("seq_retire", retire_count, 13);

        // Ready on the 15th request cycle wins over the timeout
        repeat (14) cyc();
        chk("wait14_state", current_state, 3'b000);
        chk("wait14_req", bus.imem_req, 1'b1);
        bus.imem_rdata = ADDI; bus.imem_ready = 1'b1;
        cyc(); bus.imem_ready = 1'b0;
        chk("wait15_ready_state", current_state, 3'b001);
        chk("wait15_ready_fault", fault, 1'b0);
        repeat (3) cyc();
        chk("wait15_pc", pc, 32'h30);

        // Fifteen not-ready cycles -> FAULT
        repeat (14) cyc();
        chk("to14_state", current_state, 3'b000);
        cyc();
        chk("to_state", current_state, 3'b110);
        chk("to_fault", fault, 1'b1);
        chk("to_imem_req", bus.imem_req, 1'b0);
        chk("to_pc", pc, 32'h30);
        cyc();
        chk("to_sticky", current_state, 3'b110);

        // Step mode: no fetch without credit, one pulse retires one instruction
        reset = 1'b1; step_mode = 1'b1;
        cyc();
        reset = 1'b0; #1;
        chk("step_idle_req", bus.imem_req, 1'b0);
        cyc();
        chk("step_idle_req2", bus.imem_req, 1'b0);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0; #1;
        chk("step_credit_req", bus.imem_req, 1'b1);
        exec(ADDI, 1'b0, n, wb);
        chk("step_cycles", n, 4);
        chk("step_retire", retire_count, 1);
        chk("step_after_req", bus.imem_req, 1'b0);
        repeat (3) cyc();
        chk("step_hold_state", current_state, 3'b000);
        chk("step_hold_retire", retire_count, 1);

        // Pause mid-instruction: instruction finishes, then IF idles
        step_mode = 1'b0; bus.imem_rdata = ADDI; bus.imem_ready = 1'b1;
        cyc(); bus.imem_ready = 1'b0; halt_signal = 1'b1;
        repeat (3) cyc();
        chk("pause_pc", pc, 32'h8);
        chk("pause_retire", retire_count, 2);
        chk("pause_req", bus.imem_req, 1'b0);
        repeat (2) cyc();
        chk("pause_hold_state", current_state, 3'b000);
        chk("pause_hold_req", bus.imem_req, 1'b0);

        // enable=0 holds imem_req and masks reg_write
        halt_signal = 1'b0; #1;
        chk("en_req_start", bus.imem_req, 1'b1);
        cyc();
        enable = 1'b0; halt_signal = 1'b1; #1;
        chk("en_req_hold", bus.imem_req, 1'b1);
        cyc();
        chk("en_state_hold", current_state, 3'b000);
        enable = 1'b1; #1;
        chk("en_inflight_req", bus.imem_req, 1'b1);
        bus.imem_rdata = ADDI; bus.imem_ready = 1'b1;
        cyc(); bus.imem_ready = 1'b0; halt_signal = 1'b0;
        cyc(); cyc();
        enable = 1'b0; #1;
        chk("en_wb_masked", reg_write, 1'b0);
        cyc();
        chk("en_wb_state", current_state, 3'b100);
        chk("en_wb_pc", pc, 32'h8);
        enable = 1'b1; #1;
        chk("en_wb_regwrite", reg_write, 1'b1);
        cyc();
        chk("en_pc", pc, 32'hC);
        chk("en_retire", retire_count, 3);

        // HALT opcode
        exec(HALTI, 1'b0, n, wb);
        chk("halt_cycles", n, 2);
        chk("halt_state", current_state, 3'b101);
        chk("halt_retire", retire_count, 3);
        chk("halt_fault", fault, 1'b0);
        chk("halt_req", bus.imem_req, 1'b0);
        repeat (2) cyc();
        chk("halt_sticky", current_state, 3'b101);
        chk("halt_pc", pc, 32'hC);

        // Unsupported opcode faults from EXE
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exec(BAD, 1'b0, n, wb);
        chk("bad_cycles", n, 3);
        chk("bad_state", current_state, 3'b110);
        chk("bad_fault", fault, 1'b1);
        chk("bad_retire", retire_count, 0);

        // Reset during MEM
        reset = 1'b1;
        cyc();
        reset = 1'b0; bus.imem_rdata = LW; bus.imem_ready = 1'b1;
        cyc(); bus.imem_ready = 1'b0;
        cyc(); cyc();
        chk("rmem_state", current_state, 3'b011);
        chk("rmem_dmem_req", bus.dmem_req, 1'b1);
        cyc();
        reset = 1'b1;
        cyc();
        chk("rmem_rst_state", current_state, 3'b000);
        chk("rmem_rst_pc", pc, 32'h0);
        chk("rmem_rst_dmem_req", bus.dmem_req, 1'b0);
        chk("rmem_rst_imem_req", bus.imem_req, 1'b0);
        reset = 1'b0; #1;
        chk("rmem_post_imem_req", bus.imem_req, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
